// File: rtl/capp_pkg.sv
// Shared opcode and state encodings for the CAPP search controller.
package capp_pkg;

  typedef enum logic [2:0] {
    OP_NOP        = 3'd0,
    OP_LOAD_COMP  = 3'd1,
    OP_LOAD_MASK  = 3'd2,
    OP_SEARCH     = 3'd3,
    OP_READ       = 3'd4,
    OP_WRITE      = 3'd5,
    OP_CLEAR_TAGS = 3'd6,
    OP_RSVD       = 3'd7
  } op_t;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SEARCH  = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_RESOLVE = 3'd3,
    ST_WRITE   = 3'd4
  } state_t;

endpackage

// File: rtl/capp_priority_encoder.sv
// Lowest-set-bit priority encoder: index, one-hot and none flag.
module capp_priority_encoder #(
  parameter int WORDS = 16
) (
  input  logic [WORDS-1:0]         vec,
  output logic [$clog2(WORDS)-1:0] index,
  output logic [WORDS-1:0]         onehot,
  output logic                     none
);
  localparam int IW = $clog2(WORDS);

  // Isolate the lowest set bit, then fold its position into a binary index.
  always_comb begin
    onehot = vec & (~vec + {{(WORDS-1){1'b0}}, 1'b1});
    none   = (vec == {WORDS{1'b0}});
    index  = {IW{1'b0}};
    for (int i = 0; i < WORDS; i++) begin
      index = index | (IW'(i) & {IW{onehot[i]}});
    end
  end

endmodule

// File: rtl/capp_search_controller.sv
// Command sequencer for the CAPP array: loads comparand/mask, strobes searches,
// captures tags, streams responders in priority order or issues multiple-writes.
module capp_search_controller
  import capp_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int WORDS  = 16,
  parameter int SETTLE = 1
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [2:0]                 cmd_op,
  input  logic [WIDTH-1:0]           cmd_data,
  output logic [WIDTH-1:0]           comparand,
  output logic [WIDTH-1:0]           mask,
  output logic                       perform_search,
  input  logic [WORDS-1:0]           tags_in,
  output logic                       write_enable,
  output logic [WIDTH-1:0]           write_data,
  output logic [WORDS-1:0]           write_select,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [$clog2(WORDS)-1:0]   rsp_index,
  output logic                       rsp_last,
  output logic                       rsp_empty,
  output logic                       any_match,
  output logic [$clog2(WORDS+1)-1:0] match_count
);
  localparam int IW = $clog2(WORDS);
  localparam int CW = $clog2(WORDS + 1);

  function automatic logic [CW-1:0] popcount(input logic [WORDS-1:0] v);
    logic [CW-1:0] cnt;
    cnt = {CW{1'b0}};
    for (int i = 0; i < WORDS; i++) begin
      cnt = cnt + CW'(v[i]);
    end
    return cnt;
  endfunction

  state_t           state;
  logic [WORDS-1:0] tags;
  logic [3:0]       settle_cnt;

  logic [IW-1:0]    cur_index;
  logic [WORDS-1:0] cur_onehot;
  logic             cur_none;
  logic [WORDS-1:0] rest;
  logic [IW-1:0]    nxt_index;
  logic [WORDS-1:0] nxt_onehot;
  logic             nxt_none;
  logic             rest2_empty;

  // cur: the responder now; nxt: the one after it, so the following beat is ready on handshake.
  capp_priority_encoder #(.WORDS(WORDS)) u_enc_cur (
    .vec    (tags),
    .index  (cur_index),
    .onehot (cur_onehot),
    .none   (cur_none)
  );

  assign rest = tags & ~cur_onehot;

  capp_priority_encoder #(.WORDS(WORDS)) u_enc_nxt (
    .vec    (rest),
    .index  (nxt_index),
    .onehot (nxt_onehot),
    .none   (nxt_none)
  );

  assign rest2_empty = ((rest & ~nxt_onehot) == {WORDS{1'b0}});
  assign cmd_ready   = (state == ST_IDLE);

  // Controller FSM with all array- and consumer-facing outputs registered.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state          <= ST_IDLE;
      comparand      <= {WIDTH{1'b0}};
      mask           <= {WIDTH{1'b0}};
      tags           <= {WORDS{1'b0}};
      settle_cnt     <= 4'd0;
      perform_search <= 1'b0;
      write_enable   <= 1'b0;
      write_data     <= {WIDTH{1'b0}};
      write_select   <= {WORDS{1'b0}};
      rsp_valid      <= 1'b0;
      rsp_index      <= {IW{1'b0}};
      rsp_last       <= 1'b0;
      rsp_empty      <= 1'b0;
      any_match      <= 1'b0;
      match_count    <= {CW{1'b0}};
    end else begin
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            case (op_t'(cmd_op))
              OP_LOAD_COMP: comparand <= cmd_data;
              OP_LOAD_MASK: mask <= cmd_data;
              OP_SEARCH: begin
                perform_search <= 1'b1;
                settle_cnt     <= 4'(SETTLE);
                state          <= ST_SEARCH;
              end
              OP_READ: begin
                rsp_valid <= 1'b1;
                rsp_index <= cur_index;
                rsp_empty <= cur_none;
                rsp_last  <= cur_none | nxt_none;
                state     <= ST_RESOLVE;
              end
              OP_WRITE: begin
                write_data   <= cmd_data;
                write_enable <= 1'b1;
                write_select <= tags;
                state        <= ST_WRITE;
              end
              OP_CLEAR_TAGS: begin
                tags        <= {WORDS{1'b0}};
                any_match   <= 1'b0;
                match_count <= {CW{1'b0}};
              end
              default: state <= ST_IDLE;
            endcase
          end
        end
        ST_SEARCH: begin
          if (settle_cnt <= 4'd1) begin
            perform_search <= 1'b0;
            state          <= ST_CAPTURE;
          end else begin
            settle_cnt <= settle_cnt - 4'd1;
          end
        end
        ST_CAPTURE: begin
          tags        <= tags_in;
          any_match   <= |tags_in;
          match_count <= popcount(tags_in);
          state       <= ST_IDLE;
        end
        ST_RESOLVE: begin
          if (rsp_ready) begin
            if (!rsp_empty) begin
              tags        <= rest;
              match_count <= match_count - CW'(1);
              any_match   <= ~nxt_none;
            end
            if (rsp_last) begin
              rsp_valid <= 1'b0;
              rsp_last  <= 1'b0;
              rsp_empty <= 1'b0;
              rsp_index <= {IW{1'b0}};
              state     <= ST_IDLE;
            end else begin
              rsp_index <= nxt_index;
              rsp_last  <= rest2_empty;
            end
          end
        end
        ST_WRITE: begin
          write_enable <= 1'b0;
          write_select <= {WORDS{1'b0}};
          state        <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_capp_search_controller.sv
// Scoreboard bench: a behavioural CAPP array plus reference model of the command set.
module tb_capp_search_controller;
  localparam int SETTLE = 1;

  logic        CLK = 1'b0;
  logic        RST;
  logic        cmd_valid, cmd_ready;
  logic [2:0]  cmd_op;
  logic [31:0] cmd_data, comparand, mask, write_data;
  logic        perform_search, write_enable;
  logic [15:0] tags_in, write_select;
  logic        rsp_valid, rsp_ready, rsp_last, rsp_empty, any_match;
  logic [3:0]  rsp_index;
  logic [4:0]  match_count;

  logic        d3_cmd_valid, d3_cmd_ready, d3_ps, d3_we, d3_rsp_valid, d3_rsp_last, d3_rsp_empty, d3_any;
  logic [2:0]  d3_cmd_op;
  logic [31:0] d3_comp, d3_mask, d3_wdata;
  logic [15:0] d3_wsel;
  logic [3:0]  d3_idx;
  logic [4:0]  d3_cnt;

  int checks = 0;
  int failures = 0;

  typedef struct {logic [3:0] idx; logic last; logic empty;} beat_t;
  typedef struct {logic [15:0] sel; logic [31:0] data;} wr_t;
  beat_t rsp_q[$];
  wr_t   wr_q[$];

  logic [31:0] mem [16];
  logic [31:0] m_comp, m_mask;
  logic [15:0] m_tags;
  int          stall = 0;
  bit          hold = 1'b0;
  int          ps_run = 0;

  always #5 CLK = ~CLK;

  capp_search_controller #(.WIDTH(32), .WORDS(16), .SETTLE(SETTLE)) dut (
    .CLK(CLK), .RST(RST), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_data(cmd_data), .comparand(comparand), .mask(mask), .perform_search(perform_search),
    .tags_in(tags_in), .write_enable(write_enable), .write_data(write_data),
    .write_select(write_select), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_index(rsp_index), .rsp_last(rsp_last), .rsp_empty(rsp_empty),
    .any_match(any_match), .match_count(match_count));

  capp_search_controller #(.WIDTH(32), .WORDS(16), .SETTLE(3)) dut3 (
    .CLK(CLK), .RST(RST), .cmd_valid(d3_cmd_valid), .cmd_ready(d3_cmd_ready), .cmd_op(d3_cmd_op),
    .cmd_data(32'd0), .comparand(d3_comp), .mask(d3_mask), .perform_search(d3_ps),
    .tags_in(16'h0003), .write_enable(d3_we), .write_data(d3_wdata),
    .write_select(d3_wsel), .rsp_valid(d3_rsp_valid), .rsp_ready(1'b1),
    .rsp_index(d3_idx), .rsp_last(d3_rsp_last), .rsp_empty(d3_rsp_empty),
    .any_match(d3_any), .match_count(d3_cnt));

  // Behavioural array: a word matches when it equals the comparand on all masked bits.
  always_comb begin
    for (int i = 0; i < 16; i++) tags_in[i] = (((mem[i] ^ comparand) & mask) == 32'd0);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] model_match();
    logic [15:0] r;
    for (int i = 0; i < 16; i++) r[i] = (((mem[i] ^ m_comp) & m_mask) == 32'd0);
    return r;
  endfunction

  // Monitor: drives rsp_ready and compares every presented beat / write strobe to the queues.
  always @(negedge CLK) begin
    if (hold) rsp_ready = 1'b0;
    else if (stall > 0 && rsp_valid) begin rsp_ready = 1'b0; stall--; end
    else rsp_ready = ($urandom_range(0, 3) != 0);
    if (rsp_valid) begin
      if (rsp_q.size() == 0) check("rsp_unexpected", 64'(rsp_valid), 64'd0);
      else begin
        check("rsp_index", 64'(rsp_index), 64'(rsp_q[0].idx));
        check("rsp_last", 64'(rsp_last), 64'(rsp_q[0].last));
        check("rsp_empty", 64'(rsp_empty), 64'(rsp_q[0].empty));
        if (rsp_ready) void'(rsp_q.pop_front());
      end
    end
    if (write_enable) begin
      if (wr_q.size() == 0) check("we_unexpected", 64'(write_enable), 64'd0);
      else begin
        check("write_select", 64'(write_select), 64'(wr_q[0].sel));
        check("write_data", 64'(write_data), 64'(wr_q[0].data));
        void'(wr_q.pop_front());
      end
    end
    if (perform_search) ps_run++;
    else if (ps_run > 0) begin
      check("ps_width", 64'(ps_run), 64'(SETTLE));
      ps_run = 0;
    end
  end

  task automatic send(input logic [2:0] op, input logic [31:0] data);
    int n = 0;
    @(negedge CLK);
    while (!cmd_ready && n < 100) begin @(negedge CLK); n++; end
    if (!cmd_ready) check("cmd_ready_timeout", 64'(cmd_ready), 64'd1);
    cmd_valid = 1'b1; cmd_op = op; cmd_data = data;
    @(negedge CLK);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_ready(input string name, input int limit, output int n);
    n = 0;
    while (!cmd_ready && n < limit) begin @(negedge CLK); n++; end
    if (!cmd_ready) check(name, 64'(cmd_ready), 64'd1);
  endtask

  task automatic do_load_comp(input logic [31:0] d);
    send(3'd1, d); m_comp = d;
    check("comparand", 64'(comparand), 64'(m_comp));
  endtask

  task automatic do_load_mask(input logic [31:0] d);
    send(3'd2, d); m_mask = d;
    check("mask", 64'(mask), 64'(m_mask));
  endtask

  task automatic do_search();
    int n;
    send(3'd3, 32'd0);
    wait_ready("search_timeout", 50, n);
    check("search_latency", 64'(n), 64'(SETTLE + 1));
    m_tags = model_match();
    check("any_match", 64'(any_match), 64'(m_tags != 16'd0));
    check("match_count", 64'(match_count), 64'($countones(m_tags)));
  endtask

  task automatic push_read_beats();
    beat_t b;
    if (m_tags == 16'd0) begin
      b.idx = 4'd0; b.last = 1'b1; b.empty = 1'b1; rsp_q.push_back(b);
    end else begin
      for (int i = 0; i < 16; i++) begin
        if (m_tags[i]) begin
          b.idx = 4'(i); b.last = ((m_tags >> (i + 1)) == 16'd0); b.empty = 1'b0;
          rsp_q.push_back(b);
        end
      end
    end
    m_tags = 16'd0;
  endtask

  task automatic do_read(input int st);
    int n;
    stall = st;
    push_read_beats();
    send(3'd4, 32'd0);
    wait_ready("read_timeout", 500, n);
    check("read_drained", 64'(rsp_q.size()), 64'd0);
    check("read_count", 64'(match_count), 64'd0);
    check("read_any", 64'(any_match), 64'd0);
  endtask

  task automatic do_write(input logic [31:0] d);
    wr_t w;
    int n;
    w.sel = m_tags; w.data = d; wr_q.push_back(w);
    send(3'd5, d);
    for (int i = 0; i < 16; i++)
      if (m_tags[i]) mem[i] = (mem[i] & ~m_mask) | (d & m_mask);
    wait_ready("write_timeout", 10, n);
    check("write_drained", 64'(wr_q.size()), 64'd0);
    check("write_keeps_count", 64'(match_count), 64'($countones(m_tags)));
  endtask

  task automatic do_clear();
    send(3'd6, 32'd0); m_tags = 16'd0;
    check("clear_any", 64'(any_match), 64'd0);
    check("clear_count", 64'(match_count), 64'd0);
  endtask

  task automatic do_nop(input logic [2:0] op);
    send(op, $urandom);
    check("nop_comp", 64'(comparand), 64'(m_comp));
    check("nop_mask", 64'(mask), 64'(m_mask));
    check("nop_count", 64'(match_count), 64'($countones(m_tags)));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit [4:0] ps_exp;
    bit [4:0] rdy_exp;
    int n;
    RST = 1'b1; cmd_valid = 1'b0; cmd_op = 3'd0; cmd_data = 32'd0; rsp_ready = 1'b0;
    d3_cmd_valid = 1'b0; d3_cmd_op = 3'd0;
    m_comp = 32'd0; m_mask = 32'd0; m_tags = 16'd0;
    for (int i = 0; i < 16; i++) mem[i] = 32'd0;
    repeat (3) @(posedge CLK);
    @(negedge CLK); RST = 1'b0;
    @(negedge CLK);
    check("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    check("rst_comparand", 64'(comparand), 64'd0);
    check("rst_mask", 64'(mask), 64'd0);
    check("rst_outputs", 64'({perform_search, write_enable, rsp_valid, rsp_last, rsp_empty, any_match}), 64'd0);
    check("rst_count", 64'(match_count), 64'd0);

    // Slow-settle instance: strobe width and command back-pressure with cmd_valid held.
    ps_exp = 5'b00111; rdy_exp = 5'b10000;
    d3_cmd_valid = 1'b1; d3_cmd_op = 3'd3;
    for (int k = 0; k < 5; k++) begin
      @(negedge CLK);
      check("s3_perform_search", 64'(d3_ps), 64'(ps_exp[k]));
      check("s3_cmd_ready", 64'(d3_cmd_ready), 64'(rdy_exp[k]));
    end
    d3_cmd_valid = 1'b0;
    check("s3_match_count", 64'(d3_cnt), 64'd2);
    check("s3_any_match", 64'(d3_any), 64'd1);

    // Two responders at words 0 and 4, stalled read, then an empty read.
    for (int i = 0; i < 16; i++) mem[i] = 32'h0000_1111;
    mem[0] = 32'hA5A5_1234; mem[4] = 32'hA5A5_0000;
    do_load_comp(32'hA5A5_0000);
    do_load_mask(32'hFFFF_0000);
    do_search();
    do_read(3);
    do_read(0);

    // Multiple-write to words 0 and 15.
    for (int i = 0; i < 16; i++) mem[i] = 32'd0;
    mem[0] = 32'hCAFE_0000; mem[15] = 32'hCAFE_0000;
    do_load_comp(32'hCAFE_0000);
    do_search();
    do_write(32'h1234_5678);
    do_clear();
    do_write(32'hFFFF_FFFF);

    // Reset in the middle of a responder stream.
    for (int i = 0; i < 16; i++) mem[i] = 32'd0;
    mem[1] = 32'h5A5A_5A5A; mem[2] = 32'h5A5A_5A5A;
    do_load_comp(32'h5A5A_5A5A);
    do_load_mask(32'hFFFF_FFFF);
    do_search();
    stall = 0;
    push_read_beats();
    send(3'd4, 32'd0);
    #1;
    n = 0;
    while (rsp_q.size() > 1 && n < 50) begin @(negedge CLK); #1; n++; end
    check("mid_first_beat", 64'(rsp_q.size()), 64'd1);
    hold = 1'b1;
    @(posedge CLK);
    @(negedge CLK); #1;
    RST = 1'b1;
    rsp_q.delete();
    @(negedge CLK); #1;
    RST = 1'b0;
    check("mid_rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("mid_rst_any", 64'(any_match), 64'd0);
    check("mid_rst_ready", 64'(cmd_ready), 64'd1);
    check("mid_rst_count", 64'(match_count), 64'd0);
    hold = 1'b0;
    m_comp = 32'd0; m_mask = 32'd0; m_tags = 16'd0;
    repeat (5) @(negedge CLK);

    // Randomized command mix.
    for (int i = 0; i < 16; i++) mem[i] = (32'($urandom_range(0, 3)) << 16) | 32'($urandom_range(0, 3));
    for (int it = 0; it < 200; it++) begin
      case ($urandom_range(0, 9))
        0: do_load_comp(mem[$urandom_range(0, 15)] ^ ($urandom_range(0, 1) != 0 ? 32'($urandom_range(0, 3)) : 32'd0));
        1: begin
          case ($urandom_range(0, 3))
            0: do_load_mask($urandom);
            1: do_load_mask(32'hFFFF_0000);
            2: do_load_mask(32'hFFFF_FFFF);
            default: do_load_mask(32'd0);
          endcase
        end
        2, 3, 9: do_search();
        4, 5: do_read($urandom_range(0, 2));
        6: do_write($urandom);
        7: do_clear();
        default: do_nop($urandom_range(0, 1) != 0 ? 3'd7 : 3'd0);
      endcase
    end
    repeat (4) @(negedge CLK);
    check("final_rsp_q", 64'(rsp_q.size()), 64'd0);
    check("final_wr_q", 64'(wr_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/capp_search_controller.md
Name: capp_search_controller

Overview:
Sequencer for the content-addressable parallel processor array. Accepts word-level commands over a valid/ready interface and loads the comparand and mask registers. Pulses perform_search to the array, captures the per-word match tags, and then either streams responder indices out one at a time in priority order or issues a masked multiple-write to every tagged word. Sits between the host/command source and the CAPP cell array.

Parameters:
WIDTH, 32, comparand/mask/word width in bits
WORDS, 16, number of words (tag lines) in the array
SETTLE, 1, cycles perform_search is held before tags are sampled (1..15)

Ports:
CLK  input  1  system clock, all logic on rising edge
RST  input  1  synchronous active-high reset
cmd_valid  input  1  command present
cmd_ready  output  1  controller accepts command (high only in IDLE)
cmd_op  input  3  opcode: 0 NOP, 1 LOAD_COMP, 2 LOAD_MASK, 3 SEARCH, 4 READ, 5 WRITE, 6 CLEAR_TAGS, 7 reserved
cmd_data  input  WIDTH  operand for LOAD_COMP/LOAD_MASK/WRITE
comparand  output  WIDTH  registered comparand to array
mask  output  WIDTH  registered mask to array
perform_search  output  1  search strobe to array
tags_in  input  WORDS  per-word match result from array
write_enable  output  1  one-cycle multiple-write strobe
write_data  output  WIDTH  data for multiple-write (bits applied where mask=1)
write_select  output  WORDS  words written (= captured tag vector)
rsp_valid  output  1  responder index valid
rsp_ready  input  1  consumer accepts responder
rsp_index  output  $clog2(WORDS)  index of current responder
rsp_last  output  1  final beat of a READ
rsp_empty  output  1  READ found no responders (single beat, index 0)
any_match  output  1  captured tag vector non-zero
match_count  output  $clog2(WORDS+1)  popcount of captured tags

Behaviour:
- Reset (RST high at edge): state IDLE; comparand, mask, tags, write_data, match_count = 0; perform_search, write_enable, rsp_valid, rsp_last, rsp_empty, any_match = 0; cmd_ready = 1 from the first cycle after reset. Reset mid-operation aborts any search, stream or write on the same edge. No partial response beat follows.
- States: IDLE, SEARCH, CAPTURE, RESOLVE, WRITE.
- Accept = cmd_valid & cmd_ready, only in IDLE. LOAD_COMP/LOAD_MASK: register updated on the accept edge; stays IDLE. NOP and 7: accepted, no effect. CLEAR_TAGS: tags, any_match and match_count cleared on the accept edge.
- SEARCH: accept at edge t. perform_search is high for exactly SETTLE cycles starting the cycle after t. Then CAPTURE (1 cycle): tags <= tags_in, any_match and match_count updated; back to IDLE. Result is visible SETTLE+2 cycles after accept. A search with mask=0 yields whatever the array returns; no special case.
- READ: enters RESOLVE.
  - Tags non-zero: rsp_valid high and rsp_index = lowest set tag bit. On rsp_valid & rsp_ready, that bit is cleared in the tag register and match_count is decremented. rsp_last is high on the beat holding the final set bit; after that beat the state returns to IDLE.
  - Tags zero: one beat with rsp_empty=1, rsp_last=1, rsp_index=0.
  - rsp_index, rsp_last and rsp_empty are stable while rsp_valid & !rsp_ready. There is no timeout.
- WRITE: on accept, write_data <= cmd_data. Next cycle (WRITE state): write_enable=1 and write_select = tags for one cycle; then IDLE. Tags are not modified. WRITE with zero tags still pulses write_enable, with write_select=0.
- Commands are never queued; cmd_ready is low in every non-IDLE state.

Decomposition:
- capp_pkg: opcode localparams/enum (OP_NOP..OP_CLEAR_TAGS) and state enum.
- One sub-module, capp_priority_encoder: WORDS-bit input; outputs lowest-set index, one-hot of that bit, and none flag. It is purely combinational and is used in RESOLVE.

Test Plan:
- Reset mid-stream: READ with tags=0b0110, RST asserted after the first beat -> next cycle rsp_valid=0, any_match=0, cmd_ready=1, no further beats.
- LOAD_COMP 0xA5A5_0000, LOAD_MASK 0xFFFF_0000, SEARCH (SETTLE=1) -> perform_search high exactly 1 cycle, comparand/mask hold those values; bench returns tags_in=0x0011 -> any_match=1, match_count=2 at accept+3.
- READ after the above with rsp_ready held low 3 cycles -> rsp_index=0 stable; then beats index 0 (last=0) and index 4 (last=1); then tags=0 and match_count=0.
- READ with no tags -> single beat rsp_empty=1, rsp_last=1, rsp_index=0; then IDLE.
- Tags=0x8001, WRITE cmd_data=0x1234_5678 -> one cycle write_enable=1, write_select=0x8001, write_data=0x1234_5678; tags unchanged.
- SETTLE=3 build: SEARCH -> perform_search high 3 consecutive cycles, cmd_valid held throughout sees cmd_ready=0 until CAPTURE completes.
